// File: rtl/f_fetch_ctrl.sv
// F-stage fetch sequencer: issues imem requests at f_pc, buffers the returned word while D
// is stalled, and steers the PC register including delayed branch redirects.
module f_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] f_pc,
    input  logic        d_stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] npc,
    output logic        pc_we,
    output logic [31:0] f_instr,
    output logic        f_instr_valid,
    output logic        redir_pending,
    output logic        imem_timeout,
    output logic        dbg_state
);

    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_ONE = WW'(1);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   buf_q, buf_d;
    logic          pend_q, pend_d;
    logic [31:0]   pend_tgt_q, pend_tgt_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          tout_q, tout_d;

    logic          is_fetch;
    logic          avail;
    logic          accept;
    logic [31:0]   pc_plus4;

    // Handshake: imem_req stays high in FETCH until imem_ack; the word is consumed
    // by D in the ack cycle unless d_stall, in which case it parks in buf_q (HOLD).
    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        pend_d        = pend_q;
        pend_tgt_d    = pend_tgt_q;
        wait_d        = wait_q;
        tout_d        = tout_q;

        is_fetch      = (state_q == S_FETCH);
        avail         = (is_fetch && imem_ack) || !is_fetch;
        accept        = avail && !d_stall && !reset;
        pc_plus4      = f_pc + 32'd4;

        imem_req      = is_fetch && !reset;
        imem_addr     = f_pc;
        npc           = pc_plus4;
        pc_we         = 1'b0;
        f_instr       = 32'd0;
        f_instr_valid = 1'b0;

        if (accept) begin
            pc_we         = 1'b1;
            f_instr_valid = 1'b1;
            f_instr       = is_fetch ? imem_rdata : buf_q;
            npc           = br_valid ? br_target : (pend_q ? pend_tgt_q : pc_plus4);
            pend_d        = 1'b0;
            state_d       = S_FETCH;
        end else if (is_fetch && imem_ack && d_stall) begin
            buf_d   = imem_rdata;
            state_d = S_HOLD;
        end

        // Branch resolved before its delay slot arrived: remember the target.
        if (br_valid && !d_stall && !accept) begin
            pend_d     = 1'b1;
            pend_tgt_d = br_target;
        end

        if (is_fetch) begin
            if (imem_ack) begin
                wait_d = '0;
            end else if (wait_q == WAIT_MAX) begin
                tout_d = 1'b1;
            end else begin
                wait_d = wait_q + WAIT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            buf_q      <= 32'd0;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'd0;
            wait_q     <= '0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            wait_q     <= wait_d;
            tout_q     <= tout_d;
        end
    end

    assign redir_pending = pend_q;
    assign imem_timeout  = tout_q;
    assign dbg_state     = state_q;

    // The PC register must come out of reset at the agreed boot address.
    a_reset_pc: assert property (@(posedge clk) $fell(reset) |-> (f_pc == RESET_PC));

endmodule
